tx_link_arbiter: RTL

Round-robin arbiter and handshake sequencer that shares the single serial transmitter among NREQ byte producers, such as channel samplers or status reporters. It owns the transmitter's load/send/end handshake and checks `dsr` before each transfer. It also guards each transmission with a watchdog, and returns a per-requester completion pulse with a pass/fail flag. It sits between the producers and the transmitter, in place of a single hard-wired interface FSM.

---
 rtl/tx_link_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/tx_link_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among NREQ byte producers.
// Sequences load/send/end handshake, checks dsr, and guards each frame with a watchdog.
module tx_link_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 2047
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [IDW-1:0]    cur_id,
  output logic [NREQ-1:0]   done,
  output logic              fail,
  output logic              busy,
  output logic              tx_load,
  output logic [7:0]        tx_byte,
  output logic              tx_send,
  input  logic              tx_end,
  input  logic              dsr
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_END, DONE} state_t;

  state_t          state, state_nxt;
  logic [11:0]     wd;
  logic [IDW-1:0]  ptr;
  logic            abort;
  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  cand;

  // Index arithmetic wraps modulo NREQ, which need not be a power of two.
  function automatic logic [IDW-1:0] wrap(input int unsigned v);
    int unsigned r;
    r = (v >= NREQ) ? v - NREQ : v;
    return IDW'(r);
  endfunction

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap(32'(ptr) + k);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    done      = '0;
    fail      = 1'b0;
    busy      = 1'b0;
    tx_load   = 1'b0;
    tx_send   = 1'b0;
    if (state != IDLE) begin
      busy  = 1'b1;
      grant = NREQ'(1) << cur_id;
    end
    case (state)
      IDLE:     if (pick_vld) state_nxt = LOAD;
      LOAD: begin
        tx_load   = 1'b1;
        state_nxt = dsr ? SEND : DONE;
      end
      SEND: begin
        tx_send   = 1'b1;
        state_nxt = WAIT_END;
      end
      WAIT_END: if (tx_end || wd == 12'(TIMEOUT)) state_nxt = DONE;
      DONE: begin
        done      = NREQ'(1) << cur_id;
        fail      = abort;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      wd      <= '0;
      ptr     <= '0;
      cur_id  <= '0;
      tx_byte <= '0;
      abort   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_vld) begin
          cur_id  <= pick_id;
          tx_byte <= req_data[8*pick_id +: 8];
        end
        LOAD: if (!dsr) abort <= 1'b1;
        SEND: wd <= '0;
        // tx_end wins over an expiring watchdog in the same cycle.
        WAIT_END: if (!tx_end) begin
          if (wd == 12'(TIMEOUT)) abort <= 1'b1;
          else                    wd    <= wd + 12'd1;
        end
        DONE: begin
          ptr   <= wrap(32'(cur_id) + 32'd1);
          abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
